// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared types, constant tables and round functions for the AES-128 decryption core
package aes_dec_pkg;
  typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, FINAL} aes_state_e;
  localparam logic [0:15][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // multipliers 09/0b/0d/0e all have bit 3 set, so x8 is always included
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ x8;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                           gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                           gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                           gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_inv_keyexp.sv
// aes_inv_keyexp: one AES-128 key-schedule step, forward (inv_i=0) or reverse (inv_i=1)
module aes_inv_keyexp import aes_dec_pkg::*; (
  input  logic [127:0] rk_i,
  input  logic [7:0]   rcon_i,
  input  logic         inv_i,
  output logic [127:0] rk_o
);
  logic [31:0] w0, w1, w2, w3, f0, f1, f2, f3, p0, p1, p2, p3;
  always_comb begin
    {w0, w1, w2, w3} = rk_i;
    f0 = w0 ^ sub_word(rot_word(w3)) ^ {rcon_i, 24'h0};
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    f3 = w3 ^ f2;
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    p0 = w0 ^ sub_word(rot_word(p3)) ^ {rcon_i, 24'h0};
    rk_o = inv_i ? {p0, p1, p2, p3} : {f0, f1, f2, f3};
  end
endmodule

// File: rtl/aes_dec_top.sv
// aes_dec_top: iterative AES-128 decryption, one round per clock with on-the-fly reverse key schedule.
// Define AES_DEC_KEY_CACHE_EN to cache the last round-10 key and skip expansion on a key repeat.
module aes_dec_top import aes_dec_pkg::*; (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] di,
  output logic [127:0] do1,
  output logic         done,
  output logic         busy
);
  aes_state_e   state_q;
  logic [3:0]   cnt_q, rnd_q, rcon_idx;
  logic [127:0] st_q, rk_q, ct_q, rk_d;
`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cached_key_q, cached_rk10_q;
  logic         cache_v_q;
  logic         hit;
  assign hit = cache_v_q && key == cached_key_q;
`endif
  assign rcon_idx = state_q == KEYEXP ? cnt_q : state_q == ADDKEY ? 4'd10 : rnd_q;
  aes_inv_keyexp u_ks (
    .rk_i   (rk_q),
    .rcon_i (RCON[rcon_idx]),
    .inv_i  (state_q != KEYEXP),
    .rk_o   (rk_d)
  );
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q <= IDLE;
      do1     <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      cnt_q   <= '0;
      rnd_q   <= '0;
      st_q    <= '0;
      rk_q    <= '0;
      ct_q    <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_v_q     <= 1'b0;
      cached_key_q  <= '0;
      cached_rk10_q <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          ct_q  <= di;
          cnt_q <= 4'd1;
          busy  <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
          if (hit) begin
            rk_q    <= cached_rk10_q;
            state_q <= ADDKEY;
          end else begin
            // the key is stashed now; the entry only becomes valid once its round-10 key exists
            rk_q         <= key;
            cached_key_q <= key;
            cache_v_q    <= 1'b0;
            state_q      <= KEYEXP;
          end
`else
          rk_q    <= key;
          state_q <= KEYEXP;
`endif
        end
        KEYEXP: begin
          rk_q  <= rk_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd10) begin
            state_q <= ADDKEY;
`ifdef AES_DEC_KEY_CACHE_EN
            cached_rk10_q <= rk_d;
            cache_v_q     <= 1'b1;
`endif
          end
        end
        ADDKEY: begin
          st_q    <= ct_q ^ rk_q;
          rk_q    <= rk_d;
          rnd_q   <= 4'd9;
          state_q <= ROUND;
        end
        ROUND: begin
          st_q  <= inv_mix_columns(inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_q);
          rk_q  <= rk_d;
          rnd_q <= rnd_q - 4'd1;
          if (rnd_q == 4'd1) state_q <= FINAL;
        end
        FINAL: begin
          do1     <= inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_aes_dec_top.sv
// tb_aes_dec_top: scoreboard bench for aes_dec_top (directed FIPS/SP800 vectors plus encrypt-model cross-check)
module tb_aes_dec_top;
  import aes_dec_pkg::*;
  localparam logic [127:0] K_C1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [0:3][127:0] SP_PT = {128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                                         128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
  localparam logic [0:3][127:0] SP_CT = {128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hf5d3d58503b9699de785895a96fdbaaf,
                                         128'h43b1cd7f598ece23881b00e3ed030688, 128'h7b0c785e27e8ad3f8223207104725dd4};

  typedef struct { logic [127:0] pt; int lat; int e0; } exp_t;

  logic         CLK, RST, start, done, busy;
  logic [127:0] key, di, do1;
  int           cyc, n_cmp, n_bad;
  exp_t         sb[$];
  exp_t         mon_e;
  logic         cache_v;
  logic [127:0] cache_k;

  aes_dec_top dut (.CLK(CLK), .RST(RST), .start(start), .key(key), .di(di), .do1(do1), .done(done), .busy(busy));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // plain forward AES-128, used to make ciphertexts for the random cross-check
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] rk, s, t;
    logic [7:0]   a0, a1, a2, a3;
    rk = k;
    s  = p ^ k;
    for (int r = 1; r <= 10; r++) begin
      rk[127:96] = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {RCON[r], 24'h0};
      rk[95:64]  = rk[95:64] ^ rk[127:96];
      rk[63:32]  = rk[63:32] ^ rk[95:64];
      rk[31:0]   = rk[31:0] ^ rk[63:32];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[127-8*(w+4*c) -: 8] = SBOX[s[127-8*(w+4*((c+w)%4)) -: 8]];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = t[127-32*c -: 32];
          t[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
      s = t ^ rk;
    end
    return s;
  endfunction

  // waits for IDLE (lands in the done cycle when one is pending), starts a block, queues its expectation
  task automatic issue(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p, output int lat);
    int   n;
    exp_t e;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_wait: busy=%b required 0", busy);
    end
`ifdef AES_DEC_KEY_CACHE_EN
    lat = (cache_v && k == cache_k) ? 11 : 21;
    cache_k = k;
    cache_v = 1'b1;
`else
    lat = 21;
`endif
    e.pt = p;
    e.lat = lat;
    e.e0 = cyc + 1;
    sb.push_back(e);
    key = k;
    di = c;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    key = ~k;
    di = ~c;
    chk("busy_after_start", {127'b0, busy}, 128'd1);
  endtask

  always @(negedge CLK)
    if (RST === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: do1=%h with nothing outstanding", do1);
      end else begin
        mon_e = sb.pop_front();
        chk("plaintext", do1, mon_e.pt);
        chk("latency", 128'(cyc - mon_e.e0), 128'(mon_e.lat));
        chk("busy_at_done", {127'b0, busy}, 128'd0);
      end
    end

  always @(negedge CLK)
    if (RST === 1'b1 && dut.state_q == ADDKEY && dut.ct_q == CT_B) chk("rk10_appB", dut.rk_q, RK10_B);

  initial begin
    int           lat, n;
    logic         all_busy;
    logic [127:0] k, p;
    cyc = 0;
    n_cmp = 0;
    n_bad = 0;
    cache_v = 1'b0;
    cache_k = '0;
    RST = 1'b0;
    start = 1'b0;
    key = '0;
    di = '0;
    repeat (3) @(negedge CLK);
    chk("reset_do1", do1, 128'd0);
    chk("reset_done", {127'b0, done}, 128'd0);
    chk("reset_busy", {127'b0, busy}, 128'd0);
    RST = 1'b1;
    @(negedge CLK);
    issue(K_C1, CT_C1, PT_C1, lat);
    issue(K_B, CT_B, PT_B, lat);
    issue(K_C1, CT_C1, PT_C1, lat);
    issue(K_C1, CT_C1, PT_C1, lat);
    for (int i = 0; i < 4; i++) issue(K_B, SP_CT[i], SP_PT[i], lat);
    issue(K_C1, CT_C1, PT_C1, lat);
    all_busy = 1'b1;
    for (int i = 1; i < lat; i++) begin
      @(negedge CLK);
      if (busy !== 1'b1) all_busy = 1'b0;
      start = (i == 5 || i == 15);
      key = K_B;
      di = CT_B;
    end
    start = 1'b0;
    chk("busy_continuous", {127'b0, all_busy}, 128'd1);
    issue(K_C1, CT_C1, PT_C1, lat);
    for (int i = 0; i < lat - 6; i++) @(negedge CLK);
    #1 RST = 1'b0;
    #1;
    chk("midop_reset_do1", do1, 128'd0);
    chk("midop_reset_busy", {127'b0, busy}, 128'd0);
    chk("midop_reset_done", {127'b0, done}, 128'd0);
    sb.delete();
    cache_v = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    issue(K_C1, CT_C1, PT_C1, lat);
    k = '0;
    for (int i = 0; i < 1000; i++) begin
      if (i % 4 != 3) k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      issue(k, enc(k, p), p, lat);
    end
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d blocks never completed, required 0", sb.size());
    end
    repeat (5) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
